// File: rtl/uart_pkg.sv
// Shared UART clocking definitions: default divisor widths and values.
package uart_pkg;
    localparam int DEF_DIV_W     = 16;
    localparam int DEF_FRAC_W    = 4;
    localparam int DEF_DIV_INT   = 326;
    localparam int DEF_DIV_FRAC  = 8;
    localparam int DEF_OVERSAMPLE = 16;

    typedef struct packed {
        logic [DEF_DIV_W-1:0]  divInt;
        logic [DEF_FRAC_W-1:0] divFrac;
    } divisor_t;
endpackage

// File: rtl/baud_rate_gen_frac_divider.sv
// Fractional clock divider: counts clk cycles and pulses wrap once per
// oversample period, stretching a period by one clock on each fraction carry.
module frac_divider #(
    parameter int DIV_W           = 16,
    parameter int FRAC_W          = 4,
    parameter int DEFAULT_DIV_INT = 326
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    input  logic              apply,
    input  logic [DIV_W-1:0]  divInt,
    input  logic [FRAC_W-1:0] divFrac,
    input  logic [DIV_W-1:0]  applyInt,
    output logic              wrap
);
    logic [DIV_W:0]  cnt;
    logic [DIV_W:0]  period;
    logic [FRAC_W-1:0] acc;
    logic [FRAC_W:0]   accSum;

    assign accSum = {1'b0, acc} + {1'b0, divFrac};

    // >= rather than == so a divisor shrunk while frozen cannot strand cnt above the period.
    assign wrap = en && !clr && ((cnt + (DIV_W+1)'(1)) >= period);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            acc    <= '0;
            period <= (DIV_W+1)'(DEFAULT_DIV_INT);
        end else if (clr) begin
            cnt    <= '0;
            acc    <= '0;
            period <= apply ? {1'b0, applyInt} : {1'b0, divInt};
        end else if (wrap) begin
            cnt <= '0;
            if (apply) begin
                acc    <= '0;
                period <= {1'b0, applyInt};
            end else begin
                acc    <= accSum[FRAC_W-1:0];
                period <= {1'b0, divInt} + {{DIV_W{1'b0}}, accSum[FRAC_W]};
            end
        end else begin
            if (en) begin
                cnt <= cnt + (DIV_W+1)'(1);
            end
            if (apply) begin
                acc    <= '0;
                period <= {1'b0, applyInt};
            end
        end
    end
endmodule

// File: rtl/baud_rate_gen.sv
// Programmable UART baud/oversample tick generator with bit-boundary
// deferred divisor updates.
module baud_rate_gen
    import uart_pkg::*;
#(
    parameter int DIV_W            = DEF_DIV_W,
    parameter int FRAC_W           = DEF_FRAC_W,
    parameter int OVERSAMPLE       = DEF_OVERSAMPLE,
    parameter int DEFAULT_DIV_INT  = DEF_DIV_INT,
    parameter int DEFAULT_DIV_FRAC = DEF_DIV_FRAC
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          clr,
    input  logic                          div_wr,
    input  logic [DIV_W-1:0]              div_int,
    input  logic [FRAC_W-1:0]             div_frac,
    output logic                          div_busy,
    output logic                          os_tick,
    output logic                          half_tick,
    output logic                          bit_tick,
    output logic [$clog2(OVERSAMPLE)-1:0] os_phase
);
    localparam int PH_W = $clog2(OVERSAMPLE);

    logic [DIV_W-1:0]  actInt, pendInt, wrInt, applyInt;
    logic [FRAC_W-1:0] actFrac, pendFrac, applyFrac;
    logic pendValid, immediate, direct, apply, wrap, atBitEnd;

    // div_wr is a fire-and-forget strobe (no ready); div_busy reports that a
    // captured divisor is still waiting for the next bit boundary.
    assign wrInt     = (div_int < DIV_W'(2)) ? DIV_W'(2) : div_int;
    assign immediate = clr || !en;
    assign direct    = div_wr && immediate;
    assign atBitEnd  = wrap && (os_phase == PH_W'(OVERSAMPLE-1));
    assign apply     = immediate ? (div_wr || pendValid) : (pendValid && atBitEnd);
    assign applyInt  = direct ? wrInt : pendInt;
    assign applyFrac = direct ? div_frac : pendFrac;
    assign div_busy  = pendValid;

    frac_divider #(
        .DIV_W           (DIV_W),
        .FRAC_W          (FRAC_W),
        .DEFAULT_DIV_INT (DEFAULT_DIV_INT)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .clr      (clr),
        .apply    (apply),
        .divInt   (actInt),
        .divFrac  (actFrac),
        .applyInt (applyInt),
        .wrap     (wrap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            os_tick   <= 1'b0;
            half_tick <= 1'b0;
            bit_tick  <= 1'b0;
            os_phase  <= '0;
            actInt    <= DIV_W'(DEFAULT_DIV_INT);
            actFrac   <= FRAC_W'(DEFAULT_DIV_FRAC);
            pendInt   <= '0;
            pendFrac  <= '0;
            pendValid <= 1'b0;
        end else begin
            os_tick   <= wrap;
            half_tick <= wrap && (os_phase == PH_W'(OVERSAMPLE/2-1));
            bit_tick  <= atBitEnd;
            if (clr) begin
                os_phase <= '0;
            end else if (wrap) begin
                os_phase <= os_phase + PH_W'(1);
            end
            if (apply) begin
                actInt  <= applyInt;
                actFrac <= applyFrac;
            end
            // A write landing on a bit-boundary apply becomes the next pending value.
            if (div_wr && !immediate) begin
                pendInt   <= wrInt;
                pendFrac  <= div_frac;
                pendValid <= 1'b1;
            end else if (apply) begin
                pendValid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_baud_rate_gen.sv
// Directed bench for baud_rate_gen with OVERSAMPLE=4 and a 4/0 reset divisor.
module tb_baud_rate_gen;
    import uart_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, en, clr, div_wr;
    logic [15:0] div_int;
    logic [3:0]  div_frac;
    logic        div_busy, os_tick, half_tick, bit_tick;
    logic [1:0]  os_phase;
    int          checks = 0;
    int          failures = 0;
    logic        sawTick;
    int          per[8] = '{4, 4, 5, 4, 5, 4, 5, 4};

    always #5 clk = ~clk;

    baud_rate_gen #(
        .DIV_W(16), .FRAC_W(4), .OVERSAMPLE(4), .DEFAULT_DIV_INT(4), .DEFAULT_DIV_FRAC(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .div_wr(div_wr),
        .div_int(div_int), .div_frac(div_frac), .div_busy(div_busy),
        .os_tick(os_tick), .half_tick(half_tick), .bit_tick(bit_tick), .os_phase(os_phase)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic waitTick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!os_tick && n < 200);
    endtask

    task automatic tickStep(input string tag, input int expN, input logic expHalf,
                            input logic expBit, input int expPhase);
        int n;
        waitTick(n);
        check({tag, "_cycles"}, n, expN);
        check({tag, "_half"}, half_tick, expHalf);
        check({tag, "_bit"}, bit_tick, expBit);
        check({tag, "_phase"}, os_phase, expPhase);
    endtask

    task automatic pulseWr(input divisor_t d);
        div_wr   = 1'b1;
        div_int  = d.divInt;
        div_frac = d.divFrac;
        @(negedge clk);
        div_wr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; div_wr = 1'b0; div_int = '0; div_frac = '0;
        repeat (3) @(negedge clk);
        check("rst_os_tick", os_tick, 0);
        check("rst_half_tick", half_tick, 0);
        check("rst_bit_tick", bit_tick, 0);
        check("rst_os_phase", os_phase, 0);
        check("rst_div_busy", div_busy, 0);

        // Integer divisor 4: ticks every 4 clocks, half on tick 2, bit on tick 4.
        rst_n = 1'b1; en = 1'b1;
        tickStep("int_t0", 4, 0, 0, 1);
        tickStep("int_t1", 4, 1, 0, 2);
        tickStep("int_t2", 4, 0, 0, 3);
        tickStep("int_t3", 4, 0, 1, 0);
        @(negedge clk);
        check("tick_width", os_tick, 0);

        // Fractional 4 + 8/16, loaded together with clr: periods 4,4,5,4 then 5,4,5,4.
        clr = 1'b1;
        pulseWr('{divInt: 16'd4, divFrac: 4'd8});
        clr = 1'b0;
        check("clrwr_busy", div_busy, 0);
        check("clrwr_no_tick", os_tick, 0);
        for (int k = 0; k < 8; k++) begin
            tickStep($sformatf("frac_t%0d", k), per[k], k % 4 == 1, k % 4 == 3, (k + 1) % 4);
        end

        // Deferred update: 6 then 8 written mid-bit, only 8 takes effect at the boundary.
        tickStep("defer_a", 5, 0, 0, 1);
        pulseWr('{divInt: 16'd6, divFrac: 4'd0});
        check("defer_busy1", div_busy, 1);
        tickStep("defer_b", 3, 1, 0, 2);
        pulseWr('{divInt: 16'd8, divFrac: 4'd0});
        check("defer_busy2", div_busy, 1);
        tickStep("defer_c", 4, 0, 0, 3);
        tickStep("defer_d", 4, 0, 1, 0);
        check("defer_busy_clear", div_busy, 0);
        for (int k = 0; k < 4; k++) begin
            tickStep($sformatf("div8_t%0d", k), 8, k == 1, k == 3, (k + 1) % 4);
        end

        // clr on the cycle that would have wrapped suppresses that tick.
        tickStep("clr_a", 8, 0, 0, 1);
        tickStep("clr_b", 8, 1, 0, 2);
        repeat (7) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_no_tick", os_tick, 0);
        check("clr_phase", os_phase, 0);
        tickStep("clr_after", 8, 0, 0, 1);

        // Freeze for 10 clocks mid-period: next tick shifts by exactly 10.
        repeat (3) @(negedge clk);
        en = 1'b0;
        sawTick = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (os_tick) sawTick = 1'b1;
        end
        check("freeze_no_tick", sawTick, 0);
        check("freeze_phase", os_phase, 1);
        en = 1'b1;
        tickStep("freeze_after", 5, 1, 0, 2);

        // Write while frozen applies at once; divisor 1 clamps to 2.
        en = 1'b0;
        pulseWr('{divInt: 16'd1, divFrac: 4'd0});
        en = 1'b1;
        check("frozen_wr_busy", div_busy, 0);
        tickStep("clamp_a", 2, 0, 0, 3);
        tickStep("clamp_b", 2, 0, 1, 0);

        // Reset mid-bit with a pending divisor: outputs drop at once, default returns.
        pulseWr('{divInt: 16'd5, divFrac: 4'd0});
        check("rst_pend_busy", div_busy, 1);
        tickStep("rst_pend_tick", 1, 0, 0, 1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_os_tick", os_tick, 0);
        check("async_rst_busy", div_busy, 0);
        check("async_rst_phase", os_phase, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tickStep("post_rst_a", 4, 0, 0, 1);
        tickStep("post_rst_b", 4, 1, 0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
